// File: rtl/mdio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_pkg
//  Description : Clause-22 MDIO frame constants, FSM state type and helpers.
//  Revision    : 1.0
// ============================================================================
package mdio_pkg;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    localparam logic [5:0] PRE_END   = 6'd31;
    localparam logic [5:0] HDR_END   = 6'd45;
    localparam logic [5:0] TA_END    = 6'd47;
    localparam logic [5:0] FRAME_END = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_TA   = 3'd3,
        ST_DATA = 3'd4
    } mdio_state_t;

    // Whole frame with bit 0 (first on the wire) in the MSB.
    function automatic logic [63:0] build_frame(input logic        rd,
                                                input logic [4:0]  phy,
                                                input logic [4:0]  regad,
                                                input logic [15:0] wd);
        return {32'hFFFF_FFFF, MDIO_ST, (rd ? MDIO_OP_RD : MDIO_OP_WR),
                phy, regad, MDIO_TA_WR, wd};
    endfunction

    function automatic mdio_state_t bit_region(input logic [5:0] idx);
        if (idx <= PRE_END)      return ST_PRE;
        else if (idx <= HDR_END) return ST_HDR;
        else if (idx <= TA_END)  return ST_TA;
        else                     return ST_DATA;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_frame_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_frame_engine_if
//  Description : Register-operation handshake between controller and engine.
//  Revision    : 1.0
// ============================================================================
interface mdio_frame_engine_if;
    logic        op_exec;
    logic        op_rh_wl;
    logic [4:0]  op_addr;
    logic [15:0] op_wr_data;
    logic        op_done;
    logic [15:0] op_rd_data;
    logic        op_rd_ack;
    logic        op_busy;

    modport master (
        output op_exec, op_rh_wl, op_addr, op_wr_data,
        input  op_done, op_rd_data, op_rd_ack, op_busy
    );

    modport slave (
        input  op_exec, op_rh_wl, op_addr, op_wr_data,
        output op_done, op_rd_data, op_rd_ack, op_busy
    );
endinterface
`default_nettype wire

// File: rtl/mdc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mdc_gen
//  Description : Free-running MDC divider with strobes one clk ahead of edges.
//  Revision    : 1.0
// ============================================================================
module mdc_gen #(
    parameter int HALF_DIV = 10
) (
    input  wire logic clk,
    input  wire logic rst_n,
    output logic      eth_mdc,
    output logic      rise_tick,
    output logic      fall_tick
);
    localparam logic [7:0] C_LAST = 8'(HALF_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_mdc;
    logic       w_wrap;

    assign w_wrap = (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
            r_mdc <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= 8'd0;
            r_mdc <= ~r_mdc;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Strobes are high in the cycle whose closing edge toggles MDC.
    assign rise_tick = w_wrap & ~r_mdc;
    assign fall_tick = w_wrap &  r_mdc;
    assign eth_mdc   = r_mdc;

endmodule
`default_nettype wire

// File: rtl/mdio_frame_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mdio_frame_engine
//  Description : Clause-22 MDIO master: shifts one 64-bit frame per op_exec.
//  Revision    : 1.0
// ============================================================================
module mdio_frame_engine #(
    parameter logic [4:0] PHY_ADDR = 5'b00001,
    parameter int         HALF_DIV = 10
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mdio_frame_engine_if.slave op,
    output logic               eth_mdc,
    output logic               eth_mdio_o,
    output logic               eth_mdio_oe,
    input  wire logic          eth_mdio_i
);
    import mdio_pkg::*;

    mdio_state_t r_state;
    logic [5:0]  r_bit;
    logic        r_armed;
    logic        r_rd;
    logic [4:0]  r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_shift;
    logic        r_ack_smp;
    logic [15:0] r_rd_data;
    logic        r_rd_ack;
    logic        r_done;
    logic        r_busy;
    logic        r_mdio_o;
    logic        r_mdio_oe;

    logic        w_rise;
    logic        w_fall;
    logic [5:0]  w_next_bit;
    logic        w_next_oe;
    logic [63:0] w_frame;

    mdc_gen #(.HALF_DIV(HALF_DIV)) u_mdc_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .eth_mdc   (eth_mdc),
        .rise_tick (w_rise),
        .fall_tick (w_fall)
    );

    // r_armed distinguishes "waiting to launch bit 0" from "bit 0 on the wire".
    assign w_next_bit = r_armed ? (r_bit + 6'd1) : 6'd0;
    assign w_next_oe  = !(r_rd && (w_next_bit > HDR_END));
    assign w_frame    = build_frame(r_rd, PHY_ADDR, r_addr, r_wdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit     <= 6'd0;
            r_armed   <= 1'b0;
            r_rd      <= 1'b0;
            r_addr    <= 5'd0;
            r_wdata   <= 16'd0;
            r_shift   <= 16'd0;
            r_ack_smp <= 1'b1;
            r_rd_data <= 16'd0;
            r_rd_ack  <= 1'b1;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_mdio_o  <= 1'b1;
            r_mdio_oe <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (op.op_exec) begin
                    r_rd    <= op.op_rh_wl;
                    r_addr  <= op.op_addr;
                    r_wdata <= op.op_wr_data;
                    r_busy  <= 1'b1;
                    r_bit   <= 6'd0;
                    r_armed <= 1'b0;
                    r_state <= ST_PRE;
                end
            end else begin
                if (w_rise) begin
                    if (r_state == ST_TA && r_bit == TA_END) r_ack_smp <= eth_mdio_i;
                    if (r_state == ST_DATA) r_shift <= {r_shift[14:0], eth_mdio_i};
                end
                if (w_fall) begin
                    if (r_state == ST_DATA && r_bit == FRAME_END) begin
                        r_mdio_o  <= 1'b1;
                        r_mdio_oe <= 1'b0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_armed   <= 1'b0;
                        r_state   <= ST_IDLE;
                        if (r_rd) begin
                            r_rd_data <= r_shift;
                            r_rd_ack  <= r_ack_smp;
                        end
                    end else begin
                        r_armed   <= 1'b1;
                        r_bit     <= w_next_bit;
                        r_state   <= bit_region(w_next_bit);
                        r_mdio_oe <= w_next_oe;
                        r_mdio_o  <= w_next_oe ? w_frame[FRAME_END - w_next_bit] : 1'b1;
                    end
                end
            end
        end
    end

    assign op.op_done    = r_done;
    assign op.op_busy    = r_busy;
    assign op.op_rd_data = r_rd_data;
    assign op.op_rd_ack  = r_rd_ack;
    assign eth_mdio_o    = r_mdio_o;
    assign eth_mdio_oe   = r_mdio_oe;

endmodule
`default_nettype wire

// File: tb/tb_mdio_frame_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdio_frame_engine
//  Description : Directed bench for mdio_frame_engine at HALF_DIV 10 and 2.
//  Revision    : 1.0
// ============================================================================
module tb_mdio_frame_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        exec = 1'b0;
    logic        rh_wl = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [15:0] wdata = 16'd0;
    logic        mdio_i = 1'b1;

    int vectors;
    int miscompares;
    int hd;

    always #5 clk = ~clk;

    mdio_frame_engine_if if10 ();
    mdio_frame_engine_if if2 ();

    assign if10.op_exec    = exec & ~sel;
    assign if10.op_rh_wl   = rh_wl;
    assign if10.op_addr    = addr;
    assign if10.op_wr_data = wdata;
    assign if2.op_exec     = exec & sel;
    assign if2.op_rh_wl    = rh_wl;
    assign if2.op_addr     = addr;
    assign if2.op_wr_data  = wdata;

    logic mdc10, mo10, moe10, mdc2, mo2, moe2;

    mdio_frame_engine #(.PHY_ADDR(5'b00001), .HALF_DIV(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .op(if10),
        .eth_mdc(mdc10), .eth_mdio_o(mo10), .eth_mdio_oe(moe10), .eth_mdio_i(mdio_i)
    );

    mdio_frame_engine #(.PHY_ADDR(5'b00001), .HALF_DIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .op(if2),
        .eth_mdc(mdc2), .eth_mdio_o(mo2), .eth_mdio_oe(moe2), .eth_mdio_i(mdio_i)
    );

    logic        w_mdc, w_mo, w_moe, w_done, w_busy, w_rd_ack;
    logic [15:0] w_rd_data;
    assign w_mdc     = sel ? mdc2 : mdc10;
    assign w_mo      = sel ? mo2 : mo10;
    assign w_moe     = sel ? moe2 : moe10;
    assign w_done    = sel ? if2.op_done : if10.op_done;
    assign w_busy    = sel ? if2.op_busy : if10.op_busy;
    assign w_rd_ack  = sel ? if2.op_rd_ack : if10.op_rd_ack;
    assign w_rd_data = sel ? if2.op_rd_data : if10.op_rd_data;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mdc"},     {63'd0, w_mdc},     64'd0);
        check({tag, "_mdio_o"},  {63'd0, w_mo},      64'd1);
        check({tag, "_mdio_oe"}, {63'd0, w_moe},     64'd0);
        check({tag, "_done"},    {63'd0, w_done},    64'd0);
        check({tag, "_rd_data"}, {48'd0, w_rd_data}, 64'd0);
        check({tag, "_rd_ack"},  {63'd0, w_rd_ack},  64'd1);
        check({tag, "_busy"},    {63'd0, w_busy},    64'd0);
    endtask

    // Issues one op, deserialises MDIO on MDC rises and plays a PHY on mdio_i.
    task automatic run_frame(input logic rd, input logic [4:0] a, input logic [15:0] wd,
                             input logic phy_en, input logic [15:0] phy_d,
                             input int exec2_at, input int abort_bit, input int post,
                             output logic [63:0] cap_o, output logic [63:0] cap_oe,
                             output int lat, output int ndone, output logic busy_ok,
                             output logic [15:0] d_data, output logic d_ack);
        int   cyc;
        int   bit_i;
        int   budget;
        logic prev;
        cap_o = '0; cap_oe = '0; lat = -1; ndone = 0; busy_ok = 1'b1;
        d_data = '0; d_ack = 1'b0;
        budget = 140 * hd + post + 20;
        rh_wl = rd; addr = a; wdata = wd; exec = 1'b1;
        step();
        exec = 1'b0; cyc = 0; bit_i = -1; prev = w_mdc;
        if (!w_busy) busy_ok = 1'b0;
        while (cyc < budget) begin
            step();
            cyc++;
            exec = (cyc == exec2_at);
            if (w_done) begin
                ndone++;
                if (lat < 0) begin
                    lat = cyc; d_data = w_rd_data; d_ack = w_rd_ack;
                    if (w_busy) busy_ok = 1'b0;
                end
            end else if (w_busy != (lat < 0)) begin
                busy_ok = 1'b0;
            end
            if (lat < 0 && prev && !w_mdc) begin
                bit_i++;
                if (bit_i == abort_bit) begin
                    rst_n = 1'b0;
                    break;
                end
                if (phy_en && bit_i == 47) mdio_i = 1'b0;
                else if (phy_en && bit_i >= 48 && bit_i <= 63) mdio_i = phy_d[63 - bit_i];
                else mdio_i = 1'b1;
            end
            if (lat < 0 && !prev && w_mdc && bit_i >= 0 && bit_i <= 63) begin
                cap_o[63 - bit_i]  = w_mo;
                cap_oe[63 - bit_i] = w_moe;
            end
            prev = w_mdc;
            if (lat >= 0 && cyc >= lat + post) break;
        end
        mdio_i = 1'b1;
    endtask

    logic [63:0] co, coe;
    int          lat, nd, ndone_abort;
    logic        bok;
    logic [15:0] dd;
    logic        da;

    localparam logic [63:0] C_OE_WR = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] C_OE_RD = 64'hFFFF_FFFF_FFFC_0000;

    initial begin
        vectors = 0; miscompares = 0; hd = 10;
        rst_n = 1'b0;
        repeat (3) step();
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (5) step();

        // Write reg 0 = 16'hB100
        run_frame(1'b0, 5'h00, 16'hB100, 1'b0, 16'h0, -1, -1, 20, co, coe, lat, nd, bok, dd, da);
        check("wr_frame", co, 64'hFFFF_FFFF_5082_B100);
        check("wr_oe", coe, C_OE_WR);
        check("wr_ndone", 64'(nd), 64'd1);
        check("wr_busy", {63'd0, bok}, 64'd1);
        check("wr_rd_data", {48'd0, dd}, 64'd0);
        check("wr_rd_ack", {63'd0, da}, 64'd1);
        check("wr_lat", {63'd0, (lat >= 128*hd+1 && lat <= 130*hd+2)}, 64'd1);

        // Read reg 0x19 with a PHY answering 16'hAC0C
        run_frame(1'b1, 5'h19, 16'h0, 1'b1, 16'hAC0C, -1, -1, 20, co, coe, lat, nd, bok, dd, da);
        check("rd_frame", co, 64'hFFFF_FFFF_60E7_FFFF);
        check("rd_oe", coe, C_OE_RD);
        check("rd_data", {48'd0, dd}, 64'h0000_0000_0000_AC0C);
        check("rd_ack", {63'd0, da}, 64'd0);
        check("rd_ndone", 64'(nd), 64'd1);

        // Read with no PHY present
        run_frame(1'b1, 5'h19, 16'h0, 1'b0, 16'h0, -1, -1, 20, co, coe, lat, nd, bok, dd, da);
        check("nophy_data", {48'd0, dd}, 64'h0000_0000_0000_FFFF);
        check("nophy_ack", {63'd0, da}, 64'd1);

        // Second op_exec mid-frame is ignored
        run_frame(1'b0, 5'h00, 16'hB100, 1'b0, 16'h0, 100, -1, 300, co, coe, lat, nd, bok, dd, da);
        check("dup_ndone", 64'(nd), 64'd1);
        check("dup_busy", {63'd0, bok}, 64'd1);
        check("dup_frame", co, 64'hFFFF_FFFF_5082_B100);
        check("dup_keep_rd_data", {48'd0, dd}, 64'h0000_0000_0000_FFFF);

        // Reset asserted at bit 40 of a write
        run_frame(1'b0, 5'h00, 16'hB100, 1'b0, 16'h0, -1, 40, 20, co, coe, lat, nd, bok, dd, da);
        #1;
        check_reset_values("abort");
        ndone_abort = nd;
        repeat (30) begin
            step();
            if (w_done) ndone_abort++;
        end
        rst_n = 1'b1;
        repeat (300) begin
            step();
            if (w_done || w_busy) ndone_abort++;
        end
        check("abort_no_done", 64'(ndone_abort), 64'd0);

        run_frame(1'b1, 5'h19, 16'h0, 1'b1, 16'hAC0C, -1, -1, 20, co, coe, lat, nd, bok, dd, da);
        check("post_abort_rd_frame", co, 64'hFFFF_FFFF_60E7_FFFF);
        check("post_abort_rd_data", {48'd0, dd}, 64'h0000_0000_0000_AC0C);
        check("post_abort_rd_ack", {63'd0, da}, 64'd0);

        // Back-to-back write then read on both dividers
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            hd  = (s == 1) ? 2 : 10;
            repeat (5) step();
            run_frame(1'b0, 5'h0A, 16'h1234, 1'b0, 16'h0, -1, -1, 0, co, coe, lat, nd, bok, dd, da);
            check($sformatf("b2b_wr_frame_h%0d", hd), co, 64'hFFFF_FFFF_50AA_1234);
            check($sformatf("b2b_wr_oe_h%0d", hd), coe, C_OE_WR);
            check($sformatf("b2b_wr_lat_h%0d", hd),
                  {63'd0, (lat >= 128*hd+1 && lat <= 130*hd+2)}, 64'd1);
            run_frame(1'b1, 5'h02, 16'h0, 1'b1, 16'h5A5A, -1, -1, 20, co, coe, lat, nd, bok, dd, da);
            check($sformatf("b2b_rd_frame_h%0d", hd), co, 64'hFFFF_FFFF_608B_FFFF);
            check($sformatf("b2b_rd_oe_h%0d", hd), coe, C_OE_RD);
            check($sformatf("b2b_rd_data_h%0d", hd), {48'd0, dd}, 64'h0000_0000_0000_5A5A);
            check($sformatf("b2b_rd_ack_h%0d", hd), {63'd0, da}, 64'd0);
            check($sformatf("b2b_rd_ndone_h%0d", hd), 64'(nd), 64'd1);
            check($sformatf("b2b_rd_lat_h%0d", hd),
                  {63'd0, (lat >= 128*hd+1 && lat <= 130*hd+2)}, 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
